// File: rtl/sync_fifo_ctrl_if.sv
// Valid/ready bundle for sync_fifo_ctrl.
// The slave modport is the FIFO's own view: it accepts producer words on s_*
// and presents the head word on m_*. The master modport is the surrounding
// logic, which drives the producer side and consumes the head word.
interface sync_fifo_ctrl_if #(
    parameter int DWIDTH = 32
);
    logic              s_valid;
    logic              s_ready;
    logic [DWIDTH-1:0] s_data;
    logic              m_valid;
    logic              m_ready;
    logic [DWIDTH-1:0] m_data;

    modport slave (
        input  s_valid,
        input  s_data,
        input  m_ready,
        output s_ready,
        output m_valid,
        output m_data
    );

    modport master (
        output s_valid,
        output s_data,
        output m_ready,
        input  s_ready,
        input  m_valid,
        input  m_data
    );
endinterface

// File: rtl/sync_fifo_ctrl.sv
// Synchronous valid/ready FIFO for any DEPTH >= 2 with an optional one-entry
// registered output stage, a fill-level count, almost-full/almost-empty flags
// and a synchronous flush. Full/empty decisions come from the count register,
// so pointer width never needs to be a power of two. s_ready and m_valid are
// built from registered state only (plus flush), never from m_ready.
module sync_fifo_ctrl #(
    parameter int DWIDTH   = 32,
    parameter int DEPTH    = 8,
    parameter int REG_OUT  = 1,
    parameter int CAP      = DEPTH + REG_OUT,
    parameter int AF_LEVEL = CAP - 1,
    parameter int AE_LEVEL = 1,
    parameter int CWIDTH   = $clog2(CAP + 1)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              flush,
    sync_fifo_ctrl_if.slave   bus,
    output logic [CWIDTH-1:0] count,
    output logic              almost_full,
    output logic              almost_empty
);

    localparam int PWIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CWIDTH-1:0] CAP_C = CWIDTH'(CAP);
    localparam logic [CWIDTH-1:0] AF_C = CWIDTH'(AF_LEVEL);
    localparam logic [CWIDTH-1:0] AE_C = CWIDTH'(AE_LEVEL);
    localparam logic [PWIDTH-1:0] LAST_PTR = PWIDTH'(DEPTH - 1);

    // Reject illegal parameter combinations at elaboration time.
    generate
        if (DEPTH < 2) begin : g_bad_depth
            $error("sync_fifo_ctrl: DEPTH must be at least 2");
        end
        if (REG_OUT != 0 && REG_OUT != 1) begin : g_bad_reg_out
            $error("sync_fifo_ctrl: REG_OUT must be 0 or 1");
        end
        if (CAP != DEPTH + REG_OUT) begin : g_bad_cap
            $error("sync_fifo_ctrl: CAP is derived and must equal DEPTH+REG_OUT");
        end
        if (AF_LEVEL < 1 || AF_LEVEL > CAP) begin : g_bad_af
            $error("sync_fifo_ctrl: AF_LEVEL must be within 1..CAP");
        end
        if (AE_LEVEL < 0 || AE_LEVEL > CAP - 1) begin : g_bad_ae
            $error("sync_fifo_ctrl: AE_LEVEL must be within 0..CAP-1");
        end
    endgenerate

    logic [DWIDTH-1:0] mem [DEPTH];
    logic [PWIDTH-1:0] wptr;
    logic [PWIDTH-1:0] rptr;
    logic              ready_en;
    logic              s_ready_i;
    logic              m_valid_i;
    logic              push;
    logic              pop;
    logic              rd_adv;

    assign s_ready_i    = ready_en && (count < CAP_C) && !flush;
    assign bus.s_ready  = s_ready_i;
    assign bus.m_valid  = m_valid_i;
    assign push         = bus.s_valid && s_ready_i;
    assign pop          = m_valid_i && bus.m_ready;
    assign almost_full  = (count >= AF_C);
    assign almost_empty = (count <= AE_C);

    // Holds s_ready low through reset; it opens on the first edge after release.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ready_en <= 1'b0;
        end else begin
            ready_en <= 1'b1;
        end
    end

    // Storage array; deliberately not reset or cleared by flush.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr] <= bus.s_data;
        end
    end

    // Pointers and the total fill count, which includes the output stage.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else if (flush) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                wptr <= (wptr == LAST_PTR) ? '0 : wptr + 1'b1;
            end
            if (rd_adv) begin
                rptr <= (rptr == LAST_PTR) ? '0 : rptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    generate
        if (REG_OUT != 0) begin : g_reg_out
            logic [CWIDTH-1:0] mem_cnt;
            logic              out_valid;
            logic [DWIDTH-1:0] out_data;
            logic              load;

            // Refill the output register whenever it is free this cycle.
            assign load        = (!out_valid || pop) && (mem_cnt != '0);
            assign rd_adv      = load;
            assign m_valid_i   = out_valid && !flush;
            assign bus.m_data  = out_data;

            // Output stage and the count of words still sitting in memory.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    mem_cnt   <= '0;
                    out_valid <= 1'b0;
                    out_data  <= '0;
                end else if (flush) begin
                    mem_cnt   <= '0;
                    out_valid <= 1'b0;
                end else begin
                    case ({push, load})
                        2'b10:   mem_cnt <= mem_cnt + 1'b1;
                        2'b01:   mem_cnt <= mem_cnt - 1'b1;
                        default: mem_cnt <= mem_cnt;
                    endcase
                    if (load) begin
                        out_valid <= 1'b1;
                        out_data  <= mem[rptr];
                    end else if (pop) begin
                        out_valid <= 1'b0;
                    end
                end
            end
        end else begin : g_direct_out
            assign rd_adv     = pop;
            assign m_valid_i  = (count != '0) && !flush;
            assign bus.m_data = (count != '0) ? mem[rptr] : '0;
        end
    endgenerate

endmodule
